// File: rtl/div_seq_pkg.sv
// Shared definitions for the div_seq iterative divider: op encoding,
// FSM state encoding and counter sizing.
package div_seq_pkg;

  localparam int XLEN_DFLT = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_ITER = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(XLEN_DFLT);

  function automatic int cnt_width(input int xlen);
    return (xlen < 2) ? 1 : $clog2(xlen);
  endfunction

  // DIV and REM are the signed flavours; the encoding keeps that in bit 0.
  function automatic logic is_signed_op(input logic [1:0] op_v);
    return ~op_v[0];
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring shift/subtract step: produces one quotient bit from
// the partial remainder, the dividend/quotient shifter and the divisor.
module div_seq_step import div_seq_pkg::*; #(
  parameter int XLEN = XLEN_DFLT
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  assign shifted_s = {rem_i, quo_i[XLEN-1]};
  assign trial_s   = shifted_s - {1'b0, div_i};

  // Keep the trial difference only when it did not go negative.
  always_comb begin
    rem_o = shifted_s[XLEN-1:0];
    quo_o = {quo_i[XLEN-2:0], 1'b0};
    if (!trial_s[XLEN]) begin
      rem_o = trial_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer (restoring, one bit per cycle).
// Optional build macro DIV_SEQ_FAST_EN: divide-by-zero and signed overflow bypass ITER.
module div_seq import div_seq_pkg::*; #(
  parameter int XLEN = XLEN_DFLT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = cnt_width(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_TOP = CW'(XLEN - 1);

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            done_q, done_d;

  logic            op_signed_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            b_zero_s;
  logic            ovf_s;
  logic            fast_hit_s;
  logic [XLEN-1:0] step_rem_s;
  logic [XLEN-1:0] step_quo_s;
  logic [XLEN-1:0] q_fin_s;
  logic [XLEN-1:0] r_fin_s;
  logic [XLEN-1:0] result_s;

  assign op_signed_s = is_signed_op(op_q);
  assign a_mag_s     = (op_signed_s && a_q[XLEN-1]) ? (-a_q) : a_q;
  assign b_mag_s     = (op_signed_s && b_q[XLEN-1]) ? (-b_q) : b_q;
  assign b_zero_s    = (b_q == '0);
  assign ovf_s       = op_signed_s && (a_q == MIN_NEG) && (b_q == '1);

`ifdef DIV_SEQ_FAST_EN
  assign fast_hit_s = b_zero_s | ovf_s;
`else
  assign fast_hit_s = 1'b0;
`endif

  div_seq_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (b_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Sign fix-up; a zero divisor must leave the all-ones quotient untouched.
  always_comb begin
    q_fin_s = (qneg_q && !div0_q) ? (-quo_q) : quo_q;
    r_fin_s = rneg_q ? (-rem_q) : rem_q;
    if (ovf_q) begin
      q_fin_s = MIN_NEG;
      r_fin_s = '0;
    end else begin
      q_fin_s = q_fin_s;
      r_fin_s = r_fin_s;
    end
    result_s = op_q[1] ? r_fin_s : q_fin_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; kill wins over every non-idle transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !kill) state_d = ST_PREP;
        else                state_d = ST_IDLE;
      end
      ST_PREP: begin
        if (kill)            state_d = ST_IDLE;
        else if (fast_hit_s) state_d = ST_FIN;
        else                 state_d = ST_ITER;
      end
      ST_ITER: begin
        if (kill)                 state_d = ST_IDLE;
        else if (cnt_q == '0)     state_d = ST_FIN;
        else                      state_d = ST_ITER;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next-state per state.
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    div0_d = div0_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          op_d = op;
          a_d  = op1;
          b_d  = op2;
        end else begin
          op_d = op_q;
        end
      end
      ST_PREP: begin
        if (!kill) begin
          b_d    = b_mag_s;
          rem_d  = '0;
          quo_d  = a_mag_s;
          cnt_d  = CNT_TOP;
          qneg_d = op_signed_s & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          rneg_d = op_signed_s & a_q[XLEN-1];
          div0_d = b_zero_s;
          ovf_d  = ovf_s;
          // Preload what the full iteration would have produced.
          if (fast_hit_s && b_zero_s) begin
            rem_d = a_mag_s;
            quo_d = '1;
          end else if (fast_hit_s) begin
            rem_d = '0;
            quo_d = MIN_NEG;
          end else begin
            rem_d = '0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ITER: begin
        if (!kill) begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = (cnt_q == '0) ? cnt_q : (cnt_q - CW'(1));
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FIN: begin
        if (!kill) begin
          res_d  = result_s;
          done_d = 1'b1;
        end else begin
          res_d  = res_q;
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q   <= 2'b00;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      div0_q <= div0_d;
      ovf_q  <= ovf_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
Iterative multi-cycle divider sequencer for the RV32M DIV/DIVU/REM/REMU instructions.
- Performs restoring shift/subtract division, one quotient bit per cycle.
- Sits beside the single-cycle ALU in the execute stage.
- The core stalls on busy and consumes res on the done pulse.

Parameters:
XLEN, 32, operand/result width; must be >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request a division; sampled only in IDLE
op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
op1  input  XLEN  dividend, captured with start
op2  input  XLEN  divisor, captured with start
kill  input  1  abort current operation (pipeline flush)
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse; res valid this cycle
res  output  XLEN  quotient or remainder; holds value until next done

Behaviour:
- Clock and reset: one clock (clk); reset_n is synchronous and active-low.
- Reset values: while reset_n=0 at an edge, state=IDLE, busy=0, done=0, res=0, and all internal registers are cleared.
- Reset mid-operation discards the operation with no done pulse.
- States: IDLE, PREP, ITER, FIN.
- busy = (state != IDLE), decoded from the state register.
- IDLE:
  - start=1 and kill=0: capture op, op1, op2; go to PREP.
  - start with kill=1 is dropped.
- PREP:
  - Signed ops (DIV, REM): compute |op1| and |op2|. Record quotient sign = sign(op1) XOR sign(op2), and remainder sign = sign(op1).
  - Unsigned ops: use operands unchanged, both signs positive.
  - Clear partial remainder; load quotient register with the dividend magnitude; counter = XLEN-1; go to ITER.
- ITER, one div_step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor (XLEN+1 bits).
  - If trial is non-negative: rem = trial and quotient LSB = 1; otherwise quotient LSB = 0.
  - When counter = 0, go to FIN; otherwise decrement.
- FIN:
  - Apply signs: quotient negated if its sign is negative; remainder negated if its sign is negative.
  - Select the quotient for DIV/DIVU and the remainder for REM/REMU.
  - Register res, assert done for one cycle, return to IDLE.
- Latency: start sampled at edge N; done and res visible after edge N+XLEN+3 (35 cycles for XLEN=32).
- A new start is accepted in the done cycle (state is IDLE).
- Divide by zero: quotient = all ones, remainder = op1 (RISC-V semantics). The plain algorithm yields these naturally; no special path is needed unless SIGN-fixing would corrupt them.
  - Signed DIV by zero: the quotient sign fix is suppressed, so res = all ones.
  - REM by zero: res = op1 exactly.
- Signed overflow (op1 = 100...0, op2 = all ones, DIV/REM): quotient = 100...0, remainder = 0. Enforced in FIN.
- kill:
  - In PREP, ITER or FIN, kill=1 returns to IDLE on the next edge; done is not asserted and res is unchanged.
  - kill has priority over FIN completion.
- start while busy is ignored; operands and op are not re-captured.
- Arithmetic is modulo 2^XLEN; negation is two's complement.

Optional Feature:
DIV_SEQ_FAST_EN
- Defined: PREP detects divide-by-zero and signed overflow, loads the special result, and jumps directly to FIN. done then appears after edge N+3.
  - All other operations are unchanged.
  - kill rules are identical.
- Undefined: special cases take full XLEN+3 latency. Results are identical in both builds.

Decomposition:
- Shared package holds:
  - op encoding constants: OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - state encoding: ST_IDLE, ST_PREP, ST_ITER, ST_FIN.
  - counter width constant clog2(XLEN).
- One natural combinational sub-module: div_step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - It is the single iteration; the sequencer owns all registers and the FSM.

Test Plan:
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> res=0xFFFFFFFD (-3); done exactly 35 cycles after start; busy high for cycles 1-34.
- REM op1=-7, op2=2 -> res=0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero, op1=5, op2=0:
  - DIV -> 0xFFFFFFFF; REM -> 5.
  - DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF.
  - With DIV_SEQ_FAST_EN, done 3 cycles after start.
- Overflow op1=0x80000000, op2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- DIVU 100/7 started, kill asserted 10 cycles later -> busy low next cycle, no done, res retains previous value. An immediate new start completes correctly.
- reset_n=0 mid-ITER -> busy=0, done=0, res=0 after the edge. start held high while busy with different operands -> ignored; the original result is returned. Back-to-back start in the done cycle is accepted.
